adder_sched: RTL and testbench

ADDER_SCHED -- requirements
Module: adder_sched

---
 rtl/adder_sched_pkg.sv | 11 +
 rtl/adder_sched_adder4.sv | 21 ++
 rtl/adder_sched.sv | 115 +++++++++++
 tb/tb_adder_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sched_pkg.sv
// Shared definitions for the nibble-serial, two-requester adder scheduler.
package adder_sched_pkg;
    localparam int NIB_DEFAULT = 2;
    localparam int NREQ        = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/adder_sched_adder4.sv
// 4-bit ripple-carry adder built from per-bit full adders.
module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = c[4];
endmodule

// File: rtl/adder_sched.sv
// Round-robin scheduler sharing one 4-bit adder between two requesters,
// adding NIB nibbles LSB first, one per cycle.
module adder_sched
    import adder_sched_pkg::*;
#(
    parameter int NIB = NIB_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [4*NIB-1:0]     a0,
    input  logic [4*NIB-1:0]     b0,
    input  logic [4*NIB-1:0]     a1,
    input  logic [4*NIB-1:0]     b1,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [4*NIB-1:0]     sum,
    output logic                 carry,
    output logic                 busy
);
    localparam int W  = 4 * NIB;
    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

    state_t          state_reg;
    logic [NREQ-1:0] gnt_reg;
    logic [NREQ-1:0] done_reg;
    logic [W-1:0]    sum_reg;
    logic            carry_reg;
    logic [W-1:0]    a_sh_reg;
    logic [W-1:0]    b_sh_reg;
    logic [W-1:0]    res_sh_reg;
    logic            cin_reg;
    logic            last_reg;
    logic [CW-1:0]   cnt_reg;

    logic [3:0]      nib_s;
    logic            nib_c;
    logic            win;
    logic            last_nib;
    logic [W-1:0]    res_next;

    adder4 u_adder4 (
        .a    (a_sh_reg[3:0]),
        .b    (b_sh_reg[3:0]),
        .cin  (cin_reg),
        .s    (nib_s),
        .cout (nib_c)
    );

    // Contention goes to whoever was not served last; otherwise the lone requester.
    assign win      = (req == 2'b11) ? ~last_reg : req[1];
    assign last_nib = (cnt_reg == CW'(NIB - 1));
    // Result nibbles enter at the top and shift down, so after NIB steps they sit in place.
    assign res_next = (res_sh_reg >> 4) | (W'(nib_s) << (W - 4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            gnt_reg    <= '0;
            done_reg   <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            cin_reg    <= 1'b0;
            last_reg   <= 1'b1;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= '0;
                    if (|req) begin
                        state_reg <= CALC;
                        gnt_reg   <= win ? 2'b10 : 2'b01;
                        last_reg  <= win;
                        a_sh_reg  <= win ? a1 : a0;
                        b_sh_reg  <= win ? b1 : b0;
                        cnt_reg   <= '0;
                        cin_reg   <= 1'b0;
                    end
                end
                CALC: begin
                    a_sh_reg   <= a_sh_reg >> 4;
                    b_sh_reg   <= b_sh_reg >> 4;
                    cin_reg    <= nib_c;
                    res_sh_reg <= res_next;
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (last_nib) begin
                        state_reg <= DONE;
                        sum_reg   <= res_next;
                        carry_reg <= nib_c;
                        done_reg  <= gnt_reg;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= '0;
                    gnt_reg   <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= '0;
                    gnt_reg   <= '0;
                end
            endcase
        end
    end

    assign gnt   = gnt_reg;
    assign done  = done_reg;
    assign sum   = sum_reg;
    assign carry = carry_reg;
    assign busy  = (state_reg != IDLE);
endmodule

// File: tb/tb_adder_sched.sv
// Self-checking bench for adder_sched (NIB=2): vector table, corner sequences, random ops vs model.
module tb_adder_sched;
    localparam int NIB = 2;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   gnt, done;
    logic [W-1:0] sum;
    logic         carry, busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] prev_sum;
    logic         prev_carry;
    int           model_last;

    typedef struct {
        logic [1:0]   req;
        logic [W-1:0] a0, b0, a1, b1;
        logic [1:0]   gnt;
        logic [W-1:0] sum;
        logic         carry;
    } vec_t;

    vec_t tbl [6];

    adder_sched #(.NIB(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .a0    (a0),
        .b0    (b0),
        .a1    (a1),
        .b1    (b1),
        .gnt   (gnt),
        .done  (done),
        .sum   (sum),
        .carry (carry),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " gnt"},   32'(gnt),   32'h0);
        chk({tag, " done"},  32'(done),  32'h0);
        chk({tag, " sum"},   32'(sum),   32'h0);
        chk({tag, " carry"}, 32'(carry), 32'h0);
        chk({tag, " busy"},  32'(busy),  32'h0);
    endtask

    // Asserts reset mid-cycle, checks the cleared outputs, releases after one clock.
    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        prev_sum   = '0;
        prev_carry = 1'b0;
        model_last = 1;
    endtask

    // Called just after a clock edge with the DUT idle; one full operation.
    task automatic run_op(input logic [1:0] r, input logic [W-1:0] xa0, input logic [W-1:0] xb0,
                          input logic [W-1:0] xa1, input logic [W-1:0] xb1,
                          input logic [1:0] eg, input logic [W-1:0] es, input logic ec,
                          input bit mutate, input string name);
        req = r; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
        @(posedge clk); #1;
        chk({name, " gnt@capture"},  32'(gnt),  32'(eg));
        chk({name, " busy@capture"}, 32'(busy), 32'h1);
        chk({name, " done@capture"}, 32'(done), 32'h0);
        if (mutate) begin
            a0 = W'($urandom); b0 = W'($urandom);
            a1 = W'($urandom); b1 = W'($urandom);
            req = 2'($urandom);
        end
        for (int k = 1; k < NIB; k++) begin
            @(posedge clk); #1;
            chk({name, " done@calc"}, 32'(done), 32'h0);
            chk({name, " gnt@calc"},  32'(gnt),  32'(eg));
            chk({name, " sum held"},  32'(sum),  32'(prev_sum));
            chk({name, " carry held"}, 32'(carry), 32'(prev_carry));
        end
        @(posedge clk); #1;
        chk({name, " done"},  32'(done),  32'(eg));
        chk({name, " gnt@done"}, 32'(gnt), 32'(eg));
        chk({name, " sum"},   32'(sum),   32'(es));
        chk({name, " carry"}, 32'(carry), 32'(ec));
        chk({name, " busy@done"}, 32'(busy), 32'h1);
        $display("op %s req=%b a0=%h b0=%h a1=%h b1=%h gnt=%b sum=%h carry=%b",
                 name, r, xa0, xb0, xa1, xb1, gnt, sum, carry);
        prev_sum   = es;
        prev_carry = ec;
        req = 2'b00;
        @(posedge clk); #1;
        chk({name, " done cleared"}, 32'(done), 32'h0);
        chk({name, " gnt cleared"},  32'(gnt),  32'h0);
        chk({name, " busy cleared"}, 32'(busy), 32'h0);
    endtask

    initial begin
        logic [W:0]   tot;
        logic [1:0]   r;
        logic [W-1:0] ra0, rb0, ra1, rb1, wa, wb;
        int           w;
        int           seen;
        int           last_cyc;
        logic [1:0]   exp_g;

        rst_n = 1'b0;
        req = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        prev_sum = '0; prev_carry = 1'b0; model_last = 1;

        tbl[0] = '{req: 2'b01, a0: 8'h3C, b0: 8'h0F, a1: 8'h00, b1: 8'h00, gnt: 2'b01, sum: 8'h4B, carry: 1'b0};
        tbl[1] = '{req: 2'b10, a0: 8'h00, b0: 8'h00, a1: 8'hFF, b1: 8'h01, gnt: 2'b10, sum: 8'h00, carry: 1'b1};
        tbl[2] = '{req: 2'b11, a0: 8'h80, b0: 8'h80, a1: 8'h12, b1: 8'h34, gnt: 2'b01, sum: 8'h00, carry: 1'b1};
        tbl[3] = '{req: 2'b11, a0: 8'h80, b0: 8'h80, a1: 8'h12, b1: 8'h34, gnt: 2'b10, sum: 8'h46, carry: 1'b0};
        tbl[4] = '{req: 2'b10, a0: 8'h00, b0: 8'h00, a1: 8'h0F, b1: 8'hF1, gnt: 2'b10, sum: 8'h00, carry: 1'b1};
        tbl[5] = '{req: 2'b11, a0: 8'h7F, b0: 8'h01, a1: 8'hAA, b1: 8'h55, gnt: 2'b01, sum: 8'h80, carry: 1'b0};

        #3;
        do_reset();

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].req, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
                   tbl[i].gnt, tbl[i].sum, tbl[i].carry, 1'b0, $sformatf("vec%0d", i));
        end

        // Operands changed right after capture must not affect the result.
        req = 2'b01; a0 = 8'h11; b0 = 8'h22;
        @(posedge clk); #1;
        chk("late-op gnt", 32'(gnt), 32'h1);
        a0 = 8'hEE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("late-op done",  32'(done),  32'h1);
        chk("late-op sum",   32'(sum),   32'h33);
        chk("late-op carry", 32'(carry), 32'h0);
        $display("op late-change a0=11->EE b0=22 sum=%h carry=%b", sum, carry);
        req = 2'b00;
        @(posedge clk); #1;
        prev_sum = 8'h33; prev_carry = 1'b0;

        // Both requesters held from reset: grants alternate, one done every NIB+2 cycles.
        do_reset();
        req = 2'b11; a0 = 8'h01; b0 = 8'h02; a1 = 8'h10; b1 = 8'h20;
        seen = 0; last_cyc = 0;
        for (int c = 1; c <= 40 && seen < 4; c++) begin
            @(posedge clk); #1;
            if (done != 2'b00) begin
                exp_g = (seen % 2 == 0) ? 2'b01 : 2'b10;
                chk($sformatf("rr done%0d", seen), 32'(done), 32'(exp_g));
                chk($sformatf("rr sum%0d", seen), 32'(sum), (seen % 2 == 0) ? 32'h03 : 32'h30);
                if (seen > 0)
                    chk($sformatf("rr spacing%0d", seen), 32'(c - last_cyc), 32'(NIB + 2));
                $display("op rr%0d done=%b sum=%h cycle=%0d", seen, done, sum, c);
                last_cyc = c;
                seen++;
            end
        end
        chk("rr dones seen", 32'(seen), 32'd4);
        req = 2'b00;
        repeat (NIB + 2) @(posedge clk);
        #1;

        // Reset during CALC discards the operation and restores the round-robin pointer.
        do_reset();
        req = 2'b01; a0 = 8'h55; b0 = 8'hAA;
        @(posedge clk); #1;
        chk("abort gnt", 32'(gnt), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        req = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort no done", 32'(done), 32'h0);
        end
        rst_n = 1'b1;
        prev_sum = '0; prev_carry = 1'b0; model_last = 1;
        run_op(2'b11, 8'h21, 8'h43, 8'h99, 8'h99, 2'b01, 8'h64, 1'b0, 1'b0, "after-abort");
        model_last = 0;

        // Random operations against the arithmetic / round-robin model.
        for (int i = 0; i < 40; i++) begin
            r   = 2'($urandom_range(1, 3));
            ra0 = W'($urandom); rb0 = W'($urandom);
            ra1 = W'($urandom); rb1 = W'($urandom);
            if (r == 2'b11) w = 1 - model_last;
            else            w = (r == 2'b10) ? 1 : 0;
            wa  = (w == 1) ? ra1 : ra0;
            wb  = (w == 1) ? rb1 : rb0;
            tot = {1'b0, wa} + {1'b0, wb};
            run_op(r, ra0, rb0, ra1, rb1, (w == 1) ? 2'b10 : 2'b01,
                   tot[W-1:0], tot[W], 1'($urandom), $sformatf("rand%0d", i));
            model_last = w;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
